// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion and flush kill.
// Ports: clk/rst_n (sync, active-low); flush_i kills the ID instruction;
//        id_* decoded fields from the control unit and register file;
//        stall_o (combinational) holds PC and IF/ID; ex_* registered copies for EX;
//        bubble_cnt/flush_cnt saturating event counters.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7_5,
    input  logic [1:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_write,
    output logic             stall_o,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7_5,
    output logic [1:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic uses_rs1, uses_rs2, hazard, squash, live;

    // Jumps read no rs1/rs2; stores need rs2 even though alu_src selects the immediate.
    assign uses_rs1 = ~id_jump;
    assign uses_rs2 = (~id_alu_src & ~id_jump) | id_mem_write;
    assign hazard   = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                      ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2)));
    assign stall_o  = hazard & ~flush_i;
    assign squash   = flush_i | hazard;
    // Control bits only survive for a real instruction that is actually loaded.
    assign live     = ~squash & id_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_funct3     <= '0;
            ex_funct7_5   <= 1'b0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_jump       <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            bubble_cnt    <= '0;
            flush_cnt     <= '0;
        end else begin
            ex_valid      <= live;
            ex_alu_op     <= live ? id_alu_op : 2'b00;
            ex_alu_src    <= live & id_alu_src;
            ex_branch     <= live & id_branch;
            ex_jump       <= live & id_jump;
            ex_mem_read   <= live & id_mem_read;
            ex_mem_write  <= live & id_mem_write;
            ex_mem_to_reg <= live & id_mem_to_reg;
            ex_reg_write  <= live & id_reg_write;
            // Data fields are don't-care in a bubble; holding saves enable-free toggling.
            if (!squash) begin
                ex_pc       <= id_pc;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_funct3   <= id_funct3;
                ex_funct7_5 <= id_funct7_5;
            end
            if (stall_o && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (flush_i && id_valid && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage with directed load-use cases and random traffic.
module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int CW   = 8;
    localparam logic [CW-1:0] MAX = '1;
    localparam int ADD = 0, LW = 1, JAL = 2;

    logic clk = 0, rst_n = 0, flush_i = 0, id_valid = 0;
    logic [XLEN-1:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic [2:0] id_funct3 = 0;
    logic id_funct7_5 = 0;
    logic [1:0] id_alu_op = 0;
    logic id_alu_src = 0, id_branch = 0, id_jump = 0, id_mem_read = 0;
    logic id_mem_write = 0, id_mem_to_reg = 0, id_reg_write = 0;
    logic stall_o, ex_valid, ex_funct7_5;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_funct3;
    logic [1:0] ex_alu_op;
    logic ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic [CW-1:0] bubble_cnt, flush_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_jump(id_jump), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic flush, valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
        logic f75;
        logic [1:0] op;
        logic src, br, jmp, mr, mw, m2r, rw;
    } id_t;

    typedef struct packed {
        logic valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
        logic f75;
        logic [1:0] op;
        logic src, br, jmp, mr, mw, m2r, rw;
        logic [CW-1:0] bc, fc;
    } ex_t;

    typedef struct packed { ex_t s; logic stall; } exp_t;

    exp_t q[$];
    ex_t model = '0;
    int checks = 0, errors = 0, stall_seen = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
        end
    endtask

    // A load in EX blocks an ID instruction that reads its destination register.
    function automatic logic load_use(ex_t e, id_t i);
        logic reads1, reads2;
        reads1 = !i.jmp;
        reads2 = (!i.src && !i.jmp) || i.mw;
        return e.valid && e.mr && e.rd != 0 && i.valid &&
               ((reads1 && e.rd == i.rs1) || (reads2 && e.rd == i.rs2));
    endfunction

    function automatic ex_t advance(ex_t e, id_t i, logic r);
        ex_t n;
        logic killed;
        if (!r) return '0;
        killed = i.flush || load_use(e, i);
        n = e;
        if (!killed) begin
            n.pc = i.pc; n.d1 = i.d1; n.d2 = i.d2; n.imm = i.imm;
            n.rs1 = i.rs1; n.rs2 = i.rs2; n.rd = i.rd; n.f3 = i.f3; n.f75 = i.f75;
        end
        if (killed || !i.valid) begin
            n.valid = 0; n.op = 0; n.src = 0; n.br = 0; n.jmp = 0;
            n.mr = 0; n.mw = 0; n.m2r = 0; n.rw = 0;
        end else begin
            n.valid = 1; n.op = i.op; n.src = i.src; n.br = i.br; n.jmp = i.jmp;
            n.mr = i.mr; n.mw = i.mw; n.m2r = i.m2r; n.rw = i.rw;
        end
        if (i.flush && i.valid && e.fc != MAX) n.fc = e.fc + 1;
        if (!i.flush && load_use(e, i) && e.bc != MAX) n.bc = e.bc + 1;
        return n;
    endfunction

    function automatic id_t ins(int k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        id_t i = '0;
        i.valid = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.pc = $urandom; i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
        if (k == ADD) begin i.rw = 1; i.op = 2'b10; end
        if (k == LW) begin i.mr = 1; i.m2r = 1; i.rw = 1; i.src = 1; i.f3 = 3'b010; end
        if (k == JAL) begin i.jmp = 1; i.rw = 1; end
        return i;
    endfunction

    function automatic id_t rnd();
        id_t i;
        i.flush = $urandom_range(0, 7) == 0;
        i.valid = $urandom_range(0, 7) != 0;
        i.pc = $urandom; i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
        i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3));
        i.f3 = 3'($urandom); i.f75 = 1'($urandom); i.op = 2'($urandom);
        i.src = 1'($urandom); i.br = 1'($urandom); i.jmp = $urandom_range(0, 3) == 0;
        i.mr = $urandom_range(0, 2) != 0; i.mw = 1'($urandom);
        i.m2r = 1'($urandom); i.rw = 1'($urandom);
        return i;
    endfunction

    task automatic step(input id_t i, input logic r = 1'b1);
        exp_t x;
        rst_n = r; flush_i = i.flush; id_valid = i.valid; id_pc = i.pc;
        id_rs1_data = i.d1; id_rs2_data = i.d2; id_imm = i.imm;
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_funct3 = i.f3; id_funct7_5 = i.f75;
        id_alu_op = i.op; id_alu_src = i.src; id_branch = i.br; id_jump = i.jmp;
        id_mem_read = i.mr; id_mem_write = i.mw; id_mem_to_reg = i.m2r; id_reg_write = i.rw;
        x.s = model;
        x.stall = load_use(model, i) && !i.flush;
        q.push_back(x);
        model = advance(model, i, r);
        @(posedge clk); #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (stall_o) stall_seen++;
                chk("stall_o", 64'(stall_o), 64'(e.stall));
                chk("ex_valid", 64'(ex_valid), 64'(e.s.valid));
                chk("ex_pc", 64'(ex_pc), 64'(e.s.pc));
                chk("ex_rs1_data", 64'(ex_rs1_data), 64'(e.s.d1));
                chk("ex_rs2_data", 64'(ex_rs2_data), 64'(e.s.d2));
                chk("ex_imm", 64'(ex_imm), 64'(e.s.imm));
                chk("ex_regs", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({e.s.rs1, e.s.rs2, e.s.rd}));
                chk("ex_funct", 64'({ex_funct3, ex_funct7_5}), 64'({e.s.f3, e.s.f75}));
                chk("ex_alu_op", 64'(ex_alu_op), 64'(e.s.op));
                chk("ex_ctrl", 64'({ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_mem_write,
                                    ex_mem_to_reg, ex_reg_write}),
                    64'({e.s.src, e.s.br, e.s.jmp, e.s.mr, e.s.mw, e.s.m2r, e.s.rw}));
                chk("bubble_cnt", 64'(bubble_cnt), 64'(e.s.bc));
                chk("flush_cnt", 64'(flush_cnt), 64'(e.s.fc));
            end
        end
    end

    initial begin
        id_t i;
        int s0;
        repeat (2) @(posedge clk);
        #2;
        // add x3,x1,x2
        step(ins(ADD, 3, 1, 2));
        chk("add_valid", 64'(ex_valid), 1);
        chk("add_rd", 64'(ex_rd), 3);
        chk("add_alu_op", 64'(ex_alu_op), 2);
        chk("add_reg_write", 64'(ex_reg_write), 1);
        // lw x5,0(x1); add x6,x5,x7 -> one bubble
        s0 = stall_seen;
        step(ins(LW, 5, 1, 0));
        step(ins(ADD, 6, 5, 7));
        chk("lu_bubble_valid", 64'(ex_valid), 0);
        chk("lu_bubble_ctrl", 64'({ex_reg_write, ex_mem_read, ex_alu_op}), 0);
        chk("lu_bubble_cnt", 64'(bubble_cnt), 1);
        step(ins(ADD, 6, 5, 7));
        chk("lu_consumer_valid", 64'(ex_valid), 1);
        chk("lu_consumer_rd", 64'(ex_rd), 6);
        chk("lu_stall_cycles", 64'(stall_seen - s0), 1);
        // lw x0 never stalls
        s0 = stall_seen;
        step(ins(LW, 0, 1, 0));
        step(ins(ADD, 6, 0, 0));
        step(ins(ADD, 6, 0, 0));
        chk("x0_stall_cycles", 64'(stall_seen - s0), 0);
        chk("x0_bubble_cnt", 64'(bubble_cnt), 1);
        // jal with rs1 field matching a load rd does not stall
        s0 = stall_seen;
        step(ins(LW, 5, 1, 0));
        step(ins(JAL, 1, 5, 0));
        chk("jal_stall_cycles", 64'(stall_seen - s0), 0);
        chk("jal_in_ex", 64'({ex_valid, ex_jump}), 3);
        // flush together with a load-use hazard: kill wins
        s0 = stall_seen;
        step(ins(LW, 5, 1, 0));
        i = ins(ADD, 6, 5, 7);
        i.flush = 1;
        step(i);
        chk("kill_stall_cycles", 64'(stall_seen - s0), 0);
        chk("kill_valid", 64'(ex_valid), 0);
        chk("kill_flush_cnt", 64'(flush_cnt), 1);
        chk("kill_bubble_cnt", 64'(bubble_cnt), 1);
        // repeated lw x5,0(x5) stalls every other cycle until the counter saturates
        for (int n = 0; n < 2 * int'(MAX) + 10; n++) step(ins(LW, 5, 5, 0));
        chk("sat_bubble_cnt", 64'(bubble_cnt), 64'(MAX));
        // reset in the middle of a stall
        step(ins(LW, 5, 5, 0), 1'b0);
        chk("rst_valid", 64'(ex_valid), 0);
        chk("rst_counts", 64'({bubble_cnt, flush_cnt}), 0);
        chk("rst_fields", 64'({ex_pc, ex_rd, ex_mem_read}), 0);
        for (int n = 0; n < 3000; n++) step(rnd(), $urandom_range(0, 199) != 0);
        repeat (2) @(negedge clk);
        chk("drain", 64'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with load-use hazard detection and bubble insertion for the pipelined RV32 core. It sits directly downstream of the decode-stage main control unit and register file. It captures the decoded control bits, operands and immediates on each clock and presents them to the execute stage. It also raises a stall request to the fetch and IF/ID logic on a load-use hazard, and kills the decoded instruction on a taken branch or jump flush from execute.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the saturating performance counters

- clk  in  1  rising-edge clock
- rst_n  in  1  reset: synchronous, active-low
- flush_i  in  1  taken branch/jump resolved in EX; kill the instruction currently in ID
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  sign-extended immediate selected by immSel
- id_funct3  in  3  instruction funct3
- id_funct7_5  in  1  instruction bit 30
- id_alu_op  in  2  from control unit
- id_alu_src, id_branch, id_jump, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  in  1 each  from control unit
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered copies, used by forwarding
- ex_funct3, ex_funct7_5, ex_alu_op  out  3/1/2  registered copies
- ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each  registered control
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  count of flushed ID instructions, saturating

## Operation
- Operand use is derived from the control bits:
  - uses_rs1 = ~id_jump
  - uses_rs2 = (~id_alu_src & ~id_jump) | id_mem_write
- Hazard is asserted when all of these hold:
  - ex_valid, ex_mem_read and ex_rd != 0
  - id_valid
  - either (uses_rs1 and ex_rd == id_rs1) or (uses_rs2 and ex_rd == id_rs2)
- stall_o = hazard & ~flush_i. Flush has priority, because the stalled instruction is being killed anyway.
- Each clock, the register takes exactly one of three actions:
  - LOAD when ~flush_i and ~hazard: all ex_* fields take the id_* values; ex_valid = id_valid.
  - BUBBLE when ~flush_i and hazard: ex_valid = 0; all seven control bits and ex_alu_op are 0; data fields are don't-care and are implemented as hold.
  - KILL when flush_i: same as BUBBLE.
- Invalid input is harmless: if id_valid = 0 on LOAD, ex_valid = 0 and all control bits are forced to 0, whatever the control unit drives.
- Counters:
  - bubble_cnt increments on each BUBBLE cycle.
  - flush_cnt increments on each KILL cycle in which id_valid = 1.
  - Both saturate at all-ones and never wrap.
- Register x0 never causes a hazard.
- Stores forward rs2 at EX, so a store is only stalled via the rs1 or rs2 match rule above.
- Back-to-back loads to the same rd each cause at most one bubble per consumer.

## Timing
- Reset values: every output register, ex_valid, all control bits and both counters are 0. stall_o is 0 whenever ex_valid = 0, so it reads 0 right after reset.
- Latency: exactly one cycle from ID inputs to ex_* outputs.
- stall_o is combinational, valid in the same cycle as the ID inputs, with no registered delay.
- Load-use sequence: a load-use pair produces exactly one BUBBLE cycle. On the next cycle ex_mem_read = 0, so the hazard clears and the consumer LOADs.
- Simultaneous flush and hazard: KILL wins; stall_o = 0; flush_cnt increments; bubble_cnt does not.
- rst_n low during a stall or flush: reset wins. All outputs are 0 on the next edge and counters clear.

## Test plan
- After reset, drive `add x3,x1,x2` (reg_write = 1, alu_op = 10, id_valid = 1) -> next cycle ex_valid = 1, ex_rd = 3, ex_alu_op = 10, ex_reg_write = 1, stall_o = 0.
- `lw x5,0(x1)` then `add x6,x5,x7` -> stall_o = 1 for one cycle; one bubble in EX (ex_valid = 0, all controls 0); add enters EX the following cycle; bubble_cnt = 1.
- `lw x0,0(x1)` then `add x6,x0,x0` -> stall_o never asserts; bubble_cnt = 0.
- `lw x5` then `jal x1,label` (jump = 1, id_rs1 field = 5) -> no stall, because jal does not use rs1.
- Load-use hazard with flush_i = 1 in the same cycle -> stall_o = 0, EX gets a bubble, flush_cnt = 1, bubble_cnt = 0.
- Preload bubble_cnt to 0xFFFE through repeated hazards, then 3 more hazards -> bubble_cnt holds at 0xFFFF. Then assert rst_n = 0 for 1 cycle -> all outputs 0.
